// File: rtl/gnn_feature_combiner.sv
// gnn_feature_combiner: four-lane signed multiply-accumulate over K serial
// feature elements, producing the pre-activation sums y4..y7 for the ReLu stage.
// Ports: clk, reset (sync, active-high), start, in_valid/in_ready handshake,
//   x_in (FW signed), w0..w3 (WW signed weights for y4..y7),
//   y4..y7 (YW signed results), y_valid (one-cycle pulse), busy.
// Build option: GNN_COMBINER_SATURATE_EN selects saturating reduction to YW
//   bits; when undefined the accumulators are truncated (two's-complement wrap).
module gnn_feature_combiner #(
    parameter int K  = 8,
    parameter int FW = 13,
    parameter int WW = 8,
    parameter int YW = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [FW-1:0] x_in,
    input  logic signed [WW-1:0] w0,
    input  logic signed [WW-1:0] w1,
    input  logic signed [WW-1:0] w2,
    input  logic signed [WW-1:0] w3,
    output logic signed [YW-1:0] y4,
    output logic signed [YW-1:0] y5,
    output logic signed [YW-1:0] y6,
    output logic signed [YW-1:0] y7,
    output logic                 y_valid,
    output logic                 busy
);

    localparam int CW = $clog2(K);
    localparam int AW = YW + $clog2(K);
    localparam int PW = FW + WW;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

`ifdef GNN_COMBINER_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_HI =
        {{(AW - YW + 1){1'b0}}, {(YW - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO =
        {{(AW - YW + 1){1'b1}}, {(YW - 1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic signed [AW-1:0] acc  [4];
    logic signed [WW-1:0] w    [4];
    logic signed [PW-1:0] prod [4];

    assign w[0] = w0;
    assign w[1] = w1;
    assign w[2] = w2;
    assign w[3] = w3;

    // Size casts on signed operands sign-extend, so the product is exact.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod[i] = PW'(x_in) * PW'(w[i]);
        end
    end

    function automatic logic signed [YW-1:0] reduce(
        input logic signed [AW-1:0] a
    );
`ifdef GNN_COMBINER_SATURATE_EN
        if (a > SAT_HI) begin
            return SAT_HI[YW-1:0];
        end else if (a < SAT_LO) begin
            return SAT_LO[YW-1:0];
        end else begin
            return a[YW-1:0];
        end
`else
        return a[YW-1:0];
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            y_valid  <= 1'b0;
            y4       <= '0;
            y5       <= '0;
            y6       <= '0;
            y7       <= '0;
            for (int i = 0; i < 4; i++) begin
                acc[i] <= '0;
            end
        end else begin
            y_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < 4; i++) begin
                            acc[i] <= acc[i] + AW'(prod[i]);
                        end
                        if (count == LAST) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                DONE: begin
                    y4      <= reduce(acc[0]);
                    y5      <= reduce(acc[1]);
                    y6      <= reduce(acc[2]);
                    y7      <= reduce(acc[3]);
                    y_valid <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_feature_combiner.sv
// tb_gnn_feature_combiner: directed and randomized checks of gnn_feature_combiner
// against a sum-of-products reference model.
module tb_gnn_feature_combiner;

    localparam int K = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [12:0] x_in = '0;
    logic signed [7:0]  w0 = '0;
    logic signed [7:0]  w1 = '0;
    logic signed [7:0]  w2 = '0;
    logic signed [7:0]  w3 = '0;
    logic signed [20:0] y4;
    logic signed [20:0] y5;
    logic signed [20:0] y6;
    logic signed [20:0] y7;
    logic y_valid;
    logic busy;

    int checks = 0;
    int errors = 0;
    int xs [K];
    int ws [K][4];

    always #5 clk = ~clk;

    gnn_feature_combiner #(
        .K (K),
        .FW(13),
        .WW(8),
        .YW(21)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x_in    (x_in),
        .w0      (w0),
        .w1      (w1),
        .w2      (w2),
        .w3      (w3),
        .y4      (y4),
        .y5      (y5),
        .y6      (y6),
        .y7      (y7),
        .y_valid (y_valid),
        .busy    (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reduction of an exact sum to 21 bits, by the arithmetic definition.
    function automatic longint reduce(input longint v);
`ifdef GNN_COMBINER_SATURATE_EN
        if (v > 1048575) return 1048575;
        if (v < -1048576) return -1048576;
        return v;
`else
        longint m;
        m = (v + 1048576) % 2097152;
        if (m < 0) m += 2097152;
        return m - 1048576;
`endif
    endfunction

    function automatic longint expect_lane(input int lane);
        longint s;
        s = 0;
        for (int k = 0; k < K; k++) begin
            s += longint'(xs[k]) * longint'(ws[k][lane]);
        end
        return reduce(s);
    endfunction

    task automatic junk();
        x_in = 13'($urandom);
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        w3 = 8'($urandom);
    endtask

    task automatic load_const(input int x, input int a, input int b,
                              input int c, input int d);
        for (int k = 0; k < K; k++) begin
            xs[k] = x;
            ws[k][0] = a;
            ws[k][1] = b;
            ws[k][2] = c;
            ws[k][3] = d;
        end
    endtask

    task automatic load_random();
        for (int k = 0; k < K; k++) begin
            xs[k] = int'($urandom_range(0, 8191)) - 4096;
            for (int i = 0; i < 4; i++) begin
                ws[k][i] = int'($urandom_range(0, 255)) - 128;
            end
        end
    endtask

    task automatic begin_run(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".in_ready_on"}, in_ready, 1);
        chk({tag, ".busy_on"}, busy, 1);
        chk({tag, ".y_valid_lo"}, y_valid, 0);
    endtask

    task automatic feed(input int n, input bit gaps, input bit start_mid,
                        input string tag);
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                in_valid = 1'b0;
                junk();
                tick();
                chk({tag, ".bubble_nv"}, y_valid, 0);
            end
            in_valid = 1'b1;
            x_in = 13'(xs[k]);
            w0 = 8'(ws[k][0]);
            w1 = 8'(ws[k][1]);
            w2 = 8'(ws[k][2]);
            w3 = 8'(ws[k][3]);
            start = start_mid && (k == 3);
            tick();
        end
        in_valid = 1'b0;
        start = 1'b0;
        junk();
    endtask

    task automatic finish_run(input string tag);
        chk({tag, ".done_ready"}, in_ready, 0);
        chk({tag, ".done_busy"}, busy, 1);
        chk({tag, ".done_nv"}, y_valid, 0);
        tick();
        chk({tag, ".y_valid"}, y_valid, 1);
        chk({tag, ".busy_off"}, busy, 0);
        chk({tag, ".ready_off"}, in_ready, 0);
        chk({tag, ".y4"}, y4, expect_lane(0));
        chk({tag, ".y5"}, y5, expect_lane(1));
        chk({tag, ".y6"}, y6, expect_lane(2));
        chk({tag, ".y7"}, y7, expect_lane(3));
    endtask

    task automatic hold_check(input string tag);
        in_valid = 1'b1;
        junk();
        tick();
        in_valid = 1'b0;
        chk({tag, ".pulse_end"}, y_valid, 0);
        chk({tag, ".hold_y4"}, y4, expect_lane(0));
        chk({tag, ".hold_y7"}, y7, expect_lane(3));
        chk({tag, ".idle_busy"}, busy, 0);
    endtask

    initial begin
        // Reset held two cycles under random inputs
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom);
            in_valid = 1'($urandom);
            junk();
            tick();
        end
        chk("rst.y4", y4, 0);
        chk("rst.y5", y5, 0);
        chk("rst.y6", y6, 0);
        chk("rst.y7", y7, 0);
        chk("rst.y_valid", y_valid, 0);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.busy", busy, 0);

        // Reset wins over start
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        chk("rst_start.busy", busy, 0);
        chk("rst_start.ready", in_ready, 0);
        tick();
        chk("rst_start.busy2", busy, 0);
        chk("rst_start.ready2", in_ready, 0);

        // Basic back-to-back run
        load_const(100, 2, -3, 0, 127);
        begin_run("basic");
        feed(K, 1'b0, 1'b0, "basic");
        finish_run("basic");
        chk("basic.y4c", y4, 1600);
        chk("basic.y5c", y5, -2400);
        chk("basic.y6c", y6, 0);
        chk("basic.y7c", y7, 101600);
        hold_check("basic");

        // Alternate-cycle bubbles
        begin_run("bubble");
        feed(K, 1'b1, 1'b0, "bubble");
        finish_run("bubble");
        chk("bubble.y7c", y7, 101600);
        hold_check("bubble");

        // Overflow of the 21-bit result range
        load_const(4095, 127, -128, 1, -1);
        begin_run("ovf");
        feed(K, 1'b0, 1'b0, "ovf");
        finish_run("ovf");
`ifdef GNN_COMBINER_SATURATE_EN
        chk("ovf.y4c", y4, 1048575);
        chk("ovf.y5c", y5, -1048576);
`else
        chk("ovf.y4c", y4, -33784);
        chk("ovf.y5c", y5, 1024);
`endif
        hold_check("ovf");

        // Reset mid-run abandons the partial sum
        load_random();
        begin_run("midrst");
        feed(3, 1'b0, 1'b0, "midrst");
        reset = 1'b1;
        in_valid = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("midrst.y4", y4, 0);
        chk("midrst.y5", y5, 0);
        chk("midrst.y6", y6, 0);
        chk("midrst.y7", y7, 0);
        chk("midrst.ready", in_ready, 0);
        chk("midrst.busy", busy, 0);
        for (int i = 0; i < K + 2; i++) begin
            in_valid = 1'($urandom);
            junk();
            tick();
            chk("midrst.no_valid", y_valid, 0);
        end
        in_valid = 1'b0;
        load_const(100, 2, -3, 0, 127);
        begin_run("after_rst");
        feed(K, 1'b0, 1'b0, "after_rst");
        finish_run("after_rst");

        // start while busy is ignored; start with y_valid begins a run
        begin_run("busy_start");
        feed(K, 1'b0, 1'b1, "busy_start");
        finish_run("busy_start");
        load_random();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("chain.in_ready", in_ready, 1);
        chk("chain.busy", busy, 1);
        feed(K, 1'b0, 1'b0, "chain");
        finish_run("chain");

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            load_random();
            begin_run("rand");
            feed(K, 1'($urandom), 1'($urandom), "rand");
            finish_run("rand");
            hold_check("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
